// File: rtl/linked_fifo_drain_sched_if.sv
// Signal bundle between the linked FIFO drain scheduler and its environment:
// the snooped push stream, the pop request/read data path to the linked FIFO,
// and the tagged valid/ready output stream.
// master: the scheduler. slave: the linked FIFO plus downstream consumer.
interface linked_fifo_drain_sched_if #(
  parameter int WIDTH      = 8,
  parameter int FIFOS      = 8,
  parameter int LOG2_FIFOS = (FIFOS > 1) ? $clog2(FIFOS) : 1
);
  logic                  push;
  logic [LOG2_FIFOS-1:0] push_fifo;
  logic                  pop;
  logic [LOG2_FIFOS-1:0] pop_fifo;
  logic [WIDTH-1:0]      fifo_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [LOG2_FIFOS-1:0] out_fifo;
  logic [FIFOS-1:0]      nonempty;
  logic                  err;

  modport master (
    input  push, push_fifo, fifo_q, out_ready,
    output pop, pop_fifo, out_valid, out_data, out_fifo, nonempty, err
  );

  modport slave (
    output push, push_fifo, fifo_q, out_ready,
    input  pop, pop_fifo, out_valid, out_data, out_fifo, nonempty, err
  );
endinterface

// File: rtl/linked_fifo_drain_sched.sv
// Drain scheduler for one linked FIFO. Tracks per-queue occupancy by snooping
// pushes, pops non-empty queues round-robin, captures the one-cycle-late read
// data and presents it through a 2-entry skid buffer tagged with the queue.
// Optional build macro LINKED_FIFO_SCHED_BURST_EN: allows up to BURST
// consecutive pops from the same queue before the round-robin moves on.
module linked_fifo_drain_sched #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int LOG2_FIFOS = (FIFOS > 1) ? $clog2(FIFOS) : 1,
  parameter int LOG2_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BURST      = 4
) (
  input  logic clk,
  input  logic rst,
  linked_fifo_drain_sched_if.master bus
);

  localparam int CW  = LOG2_DEPTH + 1;
  // Total occupancy gets spare headroom so an overflowing push stays visible.
  localparam int TW  = LOG2_DEPTH + LOG2_FIFOS + 1;
  localparam int CAP = DEPTH - FIFOS;

  typedef logic [LOG2_FIFOS-1:0] qid_t;

  logic [CW-1:0]    cnt_q [FIFOS];
  logic [CW-1:0]    cnt_d [FIFOS];
  logic [TW-1:0]    total_q, total_d;
  qid_t             last_q, last_d;
  logic             inflight_q;
  qid_t             inflight_id_q;
  logic [WIDTH-1:0] buf_data_q [2];
  qid_t             buf_id_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             err_q, err_d;

  logic             have_win;
  qid_t             win;
  logic             deq;
  logic             enq;
  logic             pop;
  logic [2:0]       load;
  logic [FIFOS-1:0] nonempty_v;

`ifdef LINKED_FIFO_SCHED_BURST_EN
  localparam int BW = $clog2(BURST) + 1;
  logic [BW-1:0] burst_q, burst_d;
`else
  // BURST only matters for the burst build; this block just keeps it referenced.
  if (BURST < 1) begin : g_burst_unused
  end
`endif

  // Pick the next non-empty queue after `last` from registered counts only,
  // so a same-cycle push never makes an empty queue look poppable.
  always_comb begin
    int idx;
    have_win = 1'b0;
    win      = last_q;
    idx      = 0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = FIFOS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % FIFOS;
      if (cnt_q[idx] != '0) begin
        have_win = 1'b1;
        win      = qid_t'(idx);
      end
    end
`ifdef LINKED_FIFO_SCHED_BURST_EN
    if ((cnt_q[last_q] != '0) && (burst_q < BW'(BURST - 1))) begin
      have_win = 1'b1;
      win      = last_q;
    end
`endif
  end

  // Pop only if the read data will have a buffer slot when it lands.
  always_comb begin
    deq  = (occ_q != 2'd0) && bus.out_ready;
    enq  = inflight_q;
    load = 3'(occ_q) + 3'(inflight_q);
    pop  = have_win && (load < (3'd2 + 3'(deq)));
  end

  // Next-state for counts, occupancy total, sticky error and round-robin pointer.
  always_comb begin
    for (int i = 0; i < FIFOS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.push && (bus.push_fifo == qid_t'(i))) cnt_d[i] = cnt_d[i] + CW'(1);
      if (pop && (win == qid_t'(i)))                cnt_d[i] = cnt_d[i] - CW'(1);
    end
    total_d = total_q + TW'(bus.push) - TW'(pop);
    // Any push at or beyond usable capacity overflows the linked FIFO.
    err_d   = err_q | (bus.push && (total_q >= TW'(CAP)));
    last_d  = pop ? win : last_q;
    occ_d   = occ_q + 2'(enq) - 2'(deq);
  end

`ifdef LINKED_FIFO_SCHED_BURST_EN
  // Burst length on the current queue: restarts on a switch or when it drains.
  always_comb begin
    burst_d = burst_q;
    if (pop) begin
      if ((win == last_q) && (cnt_d[win] != '0)) burst_d = burst_q + BW'(1);
      else                                       burst_d = '0;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (rst) burst_q <= '0;
    else     burst_q <= burst_d;
  end
`endif

  // Control state: counts, pointers, in-flight stage, buffer occupancy, error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFOS; i++) cnt_q[i] <= '0;
      total_q       <= '0;
      last_q        <= qid_t'(FIFOS - 1);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < FIFOS; i++) cnt_q[i] <= cnt_d[i];
      total_q       <= total_d;
      last_q        <= last_d;
      inflight_q    <= pop;
      inflight_id_q <= last_d;
      if (enq) wr_ptr_q <= ~wr_ptr_q;
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      occ_q         <= occ_d;
      err_q         <= err_d;
    end
  end

  // Buffer payload; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_data_q[wr_ptr_q] <= bus.fifo_q;
      buf_id_q[wr_ptr_q]   <= inflight_id_q;
    end
  end

  // Per-queue non-empty flags.
  always_comb begin
    for (int i = 0; i < FIFOS; i++) nonempty_v[i] = (cnt_q[i] != '0);
  end

  assign bus.pop       = pop;
  assign bus.pop_fifo  = pop ? win : last_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = buf_data_q[rd_ptr_q];
  assign bus.out_fifo  = buf_id_q[rd_ptr_q];
  assign bus.nonempty  = nonempty_v;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_linked_fifo_drain_sched.sv
// Self-checking bench for linked_fifo_drain_sched. A queue-based model of the
// linked FIFO and of the scheduling rules predicts every output each cycle.
module tb_linked_fifo_drain_sched;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int FIFOS = 8;
  localparam int BURST = 4;
  localparam int CAP   = DEPTH - FIFOS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linked_fifo_drain_sched_if #(.WIDTH(WIDTH), .FIFOS(FIFOS)) bus ();

  linked_fifo_drain_sched #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS), .BURST(BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          id;
    byte unsigned data;
  } ent_t;

  byte unsigned lq [FIFOS][$];
  int           m_cnt [FIFOS];
  int           m_last;
  bit           m_infl;
  int           m_infl_id;
  byte unsigned m_infl_data;
  ent_t         m_buf [$];
  bit           m_err;
  int           m_burst;

  int           pop_log [$];
  byte unsigned acc_log [$];

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < FIFOS; i++) s += m_cnt[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FIFOS; i++) begin
      lq[i].delete();
      m_cnt[i] = 0;
    end
    m_last = FIFOS - 1;
    m_infl = 1'b0;
    m_infl_id = 0;
    m_infl_data = 8'h00;
    m_buf.delete();
    m_err = 1'b0;
    m_burst = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input bit p, input int pf, input byte unsigned pd,
                      input bit rdy, input bit r);
    int  win;
    bit  have;
    bit  exp_pop;
    bit  deq;
    bit  same;
    int  tot;
    logic [FIFOS-1:0] ne;
    @(negedge clk);
    rst           = r;
    bus.push      = p;
    bus.push_fifo = 3'(pf);
    bus.out_ready = rdy;
    bus.fifo_q    = m_infl ? m_infl_data : 8'($urandom_range(0, 255));
    #1;
    if (r) begin
      model_reset();
    end else begin
      have = 1'b0;
      win  = m_last;
`ifdef LINKED_FIFO_SCHED_BURST_EN
      if (m_cnt[m_last] > 0 && m_burst < BURST - 1) begin
        have = 1'b1;
        win  = m_last;
      end
`endif
      for (int k = 1; k <= FIFOS && !have; k++) begin
        if (m_cnt[(m_last + k) % FIFOS] > 0) begin
          have = 1'b1;
          win  = (m_last + k) % FIFOS;
        end
      end
      deq     = (m_buf.size() > 0) && rdy;
      exp_pop = have && ((m_buf.size() + int'(m_infl) - int'(deq)) < 2);
      for (int i = 0; i < FIFOS; i++) ne[i] = (m_cnt[i] != 0);

      chk("pop",       32'(bus.pop),       32'(exp_pop));
      chk("pop_fifo",  32'(bus.pop_fifo),  32'(exp_pop ? win : m_last));
      chk("out_valid", 32'(bus.out_valid), 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        chk("out_data", 32'(bus.out_data), 32'(m_buf[0].data));
        chk("out_fifo", 32'(bus.out_fifo), 32'(m_buf[0].id));
      end
      chk("nonempty",  32'(bus.nonempty),  32'(ne));
      chk("err",       32'(bus.err),       32'(m_err));

      if (bus.pop === 1'b1) pop_log.push_back(int'(bus.pop_fifo));
      if (bus.out_valid === 1'b1 && rdy) acc_log.push_back(bus.out_data);

      tot = m_total();
      if (deq) void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back('{m_infl_id, m_infl_data});
      m_infl = exp_pop;
      if (exp_pop) begin
        same = (win == m_last);
        m_infl_id = win;
        if (lq[win].size() > 0) m_infl_data = lq[win].pop_front();
        else m_infl_data = 8'h00;
        m_cnt[win]--;
        m_burst = (same && m_cnt[win] != 0) ? m_burst + 1 : 0;
        m_last  = win;
      end
      if (p) begin
        if (tot >= CAP) m_err = 1'b1;
        lq[pf].push_back(pd);
        m_cnt[pf]++;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 8'h00, 1'b0, 1'b1);
    pop_log.delete();
    acc_log.delete();
  endtask

  initial begin
    int exp_seq [7];
    bus.push      = 1'b0;
    bus.push_fifo = '0;
    bus.out_ready = 1'b0;
    bus.fifo_q    = '0;
    model_reset();

    // Reset then idle.
    do_reset();
    do_reset();
    idle(10, 1'b1);
    chk("rst_pop",       32'(bus.pop),       32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_nonempty",  32'(bus.nonempty),  32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);

    // Two entries into q3, drained back to back.
    step(1'b1, 3, 8'h11, 1'b1, 1'b0);
    step(1'b1, 3, 8'h22, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("q3_npop", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2) begin
      chk("q3_pop0", 32'(pop_log[0]), 32'd3);
      chk("q3_pop1", 32'(pop_log[1]), 32'd3);
    end
    chk("q3_nout", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      chk("q3_out0", 32'(acc_log[0]), 32'h11);
      chk("q3_out1", 32'(acc_log[1]), 32'h22);
    end
    chk("q3_empty", 32'(bus.nonempty), 32'd0);

    // Round robin over q1, q2, q5 from a fresh reset.
    do_reset();
    step(1'b1, 1, 8'h31, 1'b1, 1'b0);
    step(1'b1, 2, 8'h32, 1'b1, 1'b0);
    step(1'b1, 5, 8'h35, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("rr_npop", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3) begin
      chk("rr_pop0", 32'(pop_log[0]), 32'd1);
      chk("rr_pop1", 32'(pop_log[1]), 32'd2);
      chk("rr_pop2", 32'(pop_log[2]), 32'd5);
    end

    // Back-pressure on q0: only two entries leave, the rest wait.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 0, 8'(8'hA0 + i), 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("bp_npop",      32'(pop_log.size()), 32'd2);
    chk("bp_out_valid", 32'(bus.out_valid),  32'd1);
    chk("bp_out_data",  32'(bus.out_data),   32'hA0);
    chk("bp_nonempty0", 32'(bus.nonempty[0]), 32'd1);
    idle(8, 1'b1);
    chk("bp_nout", 32'(acc_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++)
      chk("bp_order", 32'(acc_log[i]), 32'(8'hA0 + i));

    // Push to q4 in the same cycle it is popped with one entry.
    do_reset();
    step(1'b1, 4, 8'h41, 1'b1, 1'b0);
    step(1'b1, 4, 8'h42, 1'b1, 1'b0);
    chk("same_pop0",  32'(pop_log.size()),    32'd1);
    chk("same_cnt4",  32'(bus.nonempty[4]),   32'd1);
    idle(5, 1'b1);
    chk("same_nout",  32'(acc_log.size()),    32'd2);

    // Reset in the middle of traffic discards buffered and in-flight data.
    do_reset();
    step(1'b1, 6, 8'h61, 1'b0, 1'b0);
    step(1'b1, 6, 8'h62, 1'b0, 1'b0);
    step(1'b1, 6, 8'h63, 1'b0, 1'b0);
    step(1'b0, 0, 8'h00, 1'b1, 1'b0);
    do_reset();
    idle(1, 1'b0);
    chk("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_nonempty", 32'(bus.nonempty),  32'd0);
    chk("mid_rst_pop",      32'(bus.pop),       32'd0);

    // Burst behaviour: park q1 entries in the buffer, then load q2 x6 and q6.
    do_reset();
    step(1'b1, 1, 8'h71, 1'b0, 1'b0);
    step(1'b1, 1, 8'h72, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 2, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 6, 8'h66, 1'b0, 1'b0);
    pop_log.delete();
    idle(14, 1'b1);
`ifdef LINKED_FIFO_SCHED_BURST_EN
    exp_seq = '{2, 2, 2, 2, 6, 2, 2};
`else
    exp_seq = '{2, 6, 2, 2, 2, 2, 2};
`endif
    chk("burst_npop", 32'(pop_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < pop_log.size(); i++)
      chk("burst_seq", 32'(pop_log[i]), 32'(exp_seq[i]));

    // Overflow: fill to usable capacity, then one more push sets err.
    do_reset();
    for (int i = 0; i < CAP + 2; i++) step(1'b1, i % FIFOS, 8'(i), 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("ovf_err_before", 32'(bus.err), 32'd0);
    step(1'b1, 0, 8'hEE, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("ovf_err_set", 32'(bus.err), 32'd1);
    idle(3, 1'b1);
    chk("ovf_err_held", 32'(bus.err), 32'd1);
    do_reset();
    idle(1, 1'b0);
    chk("ovf_err_clr", 32'(bus.err), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit p;
      bit r;
      p = ($urandom_range(0, 2) != 0) && (m_total() < CAP);
      r = ($urandom_range(0, 299) == 0);
      step(p, $urandom_range(0, FIFOS - 1), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), r);
    end
    idle(40, 1'b1);
    chk("rand_drained", 32'(bus.nonempty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/linked_fifo_drain_sched.md
Name: linked_fifo_drain_sched

Overview:
- Downstream consumer of the linked FIFO, one instance per linked FIFO.
- Snoops the upstream push stream and keeps a per-queue occupancy count.
- Picks a non-empty queue round-robin and drives pop/pop_fifo into the linked FIFO.
- Captures the 1-cycle-late read data and presents it on a valid/ready output through a 2-entry skid buffer, tagged with its source queue.

Parameters:
- WIDTH, 8: data width; matches the linked FIFO WIDTH.
- DEPTH, 32: linked FIFO DEPTH; usable capacity is DEPTH-FIFOS.
- FIFOS, 8: number of logical queues.
- LOG2_FIFOS, log2(FIFOS-1): queue index width.
- LOG2_DEPTH, log2(DEPTH-1): per-queue counts are LOG2_DEPTH+1 bits.
- BURST, 4: maximum consecutive pops from one queue; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  snooped linked FIFO push.
- push_fifo  in  LOG2_FIFOS  snooped push queue index.
- pop  out  1  pop request to the linked FIFO.
- pop_fifo  out  LOG2_FIFOS  queue to pop.
- fifo_q  in  WIDTH  linked FIFO q; valid the cycle after pop.
- out_valid  out  1  output entry available.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  WIDTH  head entry data.
- out_fifo  out  LOG2_FIFOS  head entry source queue.
- nonempty  out  FIFOS  bit i=1 when cnt[i]!=0.
- err  out  1  sticky protocol error.

Behaviour:
- Reset, applied on the clock edge with rst=1:
  - cnt[*]=0, last=FIFOS-1, inflight=0, buffer empty, err=0.
  - Outputs: pop=0, out_valid=0, nonempty=0.
  - out_data and out_fifo are don't-care while out_valid=0.
  - rst mid-operation discards buffered and in-flight data; the linked FIFO shares rst.
- Counts:
  - push to queue i: cnt[i]+1.
  - pop of queue i: cnt[i]-1.
  - push and pop to the same queue in the same cycle: cnt[i] unchanged.
  - The push and pop sides are evaluated independently for different queues.
  - Counts update on the clock edge.
- err is set and held until rst when:
  - a push would take the sum of all cnt above DEPTH-FIFOS, or
  - a push arrives while occupancy = DEPTH-FIFOS.
- Selection (combinational, from registered state):
  - Search order: last+1, last+2, ... wrapping modulo FIFOS.
  - Winner is the first queue with cnt!=0.
  - Same-cycle pushes do not make a queue eligible. This guarantees no pop of an empty linked queue and no same-queue push/pop on an empty queue.
- Pop enable:
  - Condition: pop=1 iff a winner exists and occ + inflight - (out_valid & out_ready) < 2.
  - occ is buffer occupancy (0..2).
  - pop_fifo = winner. On pop, last <= winner.
  - When pop=0, pop_fifo = last.
- In-flight stage:
  - inflight <= pop; inflight_id <= pop_fifo.
  - When inflight=1, fifo_q is written into the buffer tail with inflight_id in that cycle.
- Output buffer:
  - 2-entry FIFO; out_* show the head.
  - Dequeue when out_valid & out_ready.
  - Enqueue and dequeue may happen in the same cycle.
  - Overflow is impossible by construction; out_valid=1 whenever occ>0.
- Latency and throughput:
  - Entry counted -> pop issued the next cycle at earliest.
  - Pop -> out_valid 2 cycles later (capture, then registered buffer).
  - Sustained rate is 1 entry/cycle with out_ready held high.
- Back-pressure:
  - With out_ready=0, at most 2 entries leave the linked FIFO; pops then stop.
  - cnt values are retained.
- Startup: after rst the linked FIFO ignores traffic during its init. The scheduler issues no pops until snooped pushes arrive, so no special wait is needed.

Optional Feature:
- Macro: LINKED_FIFO_SCHED_BURST_EN.
- Defined:
  - A burst counter (reset 0) lets the scheduler stay on queue `last` while cnt[last]!=0 and burst < BURST-1.
  - The counter increments on each pop of the same queue.
  - It clears on a switch, or when the queue empties.
  - After BURST consecutive pops, the round-robin search resumes from last+1.
- Undefined: strict one-pop-per-turn round-robin as above; no burst counter logic is present.

Test Plan:
- Reset then idle 10 cycles -> pop=0, out_valid=0, nonempty=0, err=0.
- Push d=0x11,0x22 to q3, out_ready=1:
  - pops of q3 on consecutive cycles;
  - out_data 0x11 then 0x22, out_fifo=3;
  - cnt[3] returns to 0.
- One entry each in q1, q2, q5, round-robin, out_ready=1 -> output order q1, q2, q5 (start point last=7 after reset).
- 5 entries in q0, out_ready=0 for 10 cycles:
  - exactly 2 pops; out_valid=1 holding the first entry; cnt[0]=3.
  - Raising out_ready drains the remaining 3 entries in order, no loss or duplication.
- Same-cycle push to q4 while popping q4 with cnt[4]=1 -> cnt[4] stays 1; that push is not eligible before the next cycle.
- Assert rst with 2 entries buffered and 1 in flight -> next cycle out_valid=0, counts 0.
- BURST_EN with BURST=4, 6 entries in q2 and 1 in q6 -> pop sequence q2 ×4, q6, q2 ×2.
- Without the macro, same stimulus -> q2, q6, q2 ×5.
